// File: rtl/pixel_feed_seq.sv
// rtl/pixel_feed_seq.sv - collects N pixels, converts them to floats, then streams
// them followed by N*M+M parameter ROM words to a downstream classifier.
module pixel_feed_seq #(
  parameter int N = 3,
  parameter int M = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic [17:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] data_out,
  output logic        cls_reset,
  output logic        busy,
  output logic        done
);

  localparam int T  = N + N * M + M;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [17:0] FEAT_LAST = 18'(N - 1);
  localparam logic [17:0] FEAT_END  = 18'(N);
  localparam logic [17:0] ADDR_LAST = 18'(T - 2);
  localparam logic [17:0] WORD_LAST = 18'(T - 1);
  localparam logic [IW-1:0] CNT_LAST = IW'(N - 1);

  typedef enum logic [1:0] {COLLECT, FEAT, PARAM, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [17:0]   wcnt_q, wcnt_d;
  logic [17:0]   rom_addr_q, rom_addr_d;
  logic          pix_ready_q, pix_ready_d;
  logic          cls_reset_q, cls_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   buf_q [N];
  logic [31:0]   buf_d [N];
  logic          accept;
  logic [IW-1:0] idx;

  // Exact unsigned-byte to IEEE-754 single: every 8-bit value fits the mantissa.
  function automatic logic [31:0] pix_to_float(input logic [7:0] p);
    logic [2:0]  msb;
    logic [23:0] sh;
    msb = '0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) msb = 3'(i);
    end
    sh = {p, 16'b0} << (3'd7 - msb);
    if (p == 8'd0) return 32'd0;
    return {1'b0, 8'd127 + {5'b0, msb}, sh[22:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    rom_addr_d  = rom_addr_q;
    pix_ready_d = pix_ready_q;
    cls_reset_d = cls_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    buf_d       = buf_q;
    accept      = pix_valid && pix_ready_q;
    idx         = (state_q == DONE) ? '0 : cnt_q;

    case (state_q)
      COLLECT, DONE: begin
        if (accept) begin
          buf_d[idx] = pix_to_float(pix_data);
          done_d     = 1'b0;
          if (idx == CNT_LAST) begin
            state_d     = FEAT;
            cnt_d       = '0;
            wcnt_d      = '0;
            pix_ready_d = 1'b0;
            cls_reset_d = 1'b0;
            busy_d      = 1'b1;
            // With a single feature the first FEAT cycle already prefetches ROM word 0.
            if (N == 1) rom_addr_d = '0;
          end else begin
            state_d     = COLLECT;
            cnt_d       = idx + 1'b1;
            pix_ready_d = 1'b1;
            cls_reset_d = 1'b1;
            busy_d      = 1'b0;
          end
        end
      end
      FEAT, PARAM: begin
        if (state_q == PARAM && wcnt_q == WORD_LAST) begin
          state_d     = DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          pix_ready_d = 1'b1;
          cls_reset_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + 18'd1;
          // ROM has one cycle of latency, so the address leads its word by one cycle.
          if (wcnt_d >= FEAT_LAST && wcnt_d <= ADDR_LAST) rom_addr_d = wcnt_d - FEAT_LAST;
          if (wcnt_d == FEAT_END) state_d = PARAM;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      rom_addr_q  <= '0;
      pix_ready_q <= 1'b1;
      cls_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      rom_addr_q  <= rom_addr_d;
      pix_ready_q <= pix_ready_d;
      cls_reset_q <= cls_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    data_out = 32'd0;
    case (state_q)
      FEAT:    data_out = buf_q[wcnt_q[IW-1:0]];
      PARAM:   data_out = rom_data;
      default: data_out = 32'd0;
    endcase
  end

  assign pix_ready = pix_ready_q;
  assign rom_addr  = rom_addr_q;
  assign cls_reset = cls_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
